// File: rtl/tx_arbiter_if.sv
// Requester-side and UART-side signals of the transmit arbiter.
// The arbiter uses the slave modport; whatever drives requests and the UART uses master.
interface tx_arbiter_if;
  logic [2:0] req;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] last;
  logic [2:0] ack;
  logic       tx_busy;
  logic [7:0] tx_in;
  logic       tx_write;
  logic [1:0] owner;
  logic       lock_err;

  modport slave (
    input  req, data0, data1, data2, last, tx_busy,
    output ack, tx_in, tx_write, owner, lock_err
  );

  modport master (
    output req, data0, data1, data2, last, tx_busy,
    input  ack, tx_in, tx_write, owner, lock_err
  );
endinterface

// File: rtl/tx_arbiter.sv
// Three-requester UART transmit arbiter with per-frame locking, round-robin
// selection between frames, an inter-byte gap and a lock timeout.
module tx_arbiter #(
  parameter int GAP_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  localparam int                 GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'(GAP_CYCLES);
  localparam logic [11:0]        LOCK_LIMIT = 12'(LOCK_TIMEOUT);
  localparam logic [1:0]         NO_OWNER   = 2'd3;

  state_t            state_q, state_d;
  logic [1:0]        owner_q, last_grant_q;
  logic [10:0]       lock_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              wait_first_q;
  logic [7:0]        tx_in_q;
  logic              tx_write_q;
  logic [2:0]        ack_q;
  logic              lock_err_q;

  logic              locked;
  logic              owner_req, owner_last;
  logic [7:0]        owner_data;
  logic [1:0]        pick, cand;
  logic              pick_ok;
  logic              start_grant, issue, timeout_hit, gap_load, lock_cnt_run;

  assign locked = (owner_q != NO_OWNER);

  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = 8'h00;
    case (owner_q)
      2'd0: begin owner_req = bus.req[0]; owner_last = bus.last[0]; owner_data = bus.data0; end
      2'd1: begin owner_req = bus.req[1]; owner_last = bus.last[1]; owner_data = bus.data1; end
      2'd2: begin owner_req = bus.req[2]; owner_last = bus.last[2]; owner_data = bus.data2; end
      default: ;
    endcase
  end

  // Scan from the farthest candidate to the nearest so the one just after last_grant wins.
  always_comb begin
    pick    = 2'd0;
    pick_ok = 1'b0;
    cand    = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = 2'((int'(last_grant_q) + 1 + k) % 3);
      if (bus.req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_grant  = 1'b0;
    issue        = 1'b0;
    timeout_hit  = 1'b0;
    gap_load     = 1'b0;
    lock_cnt_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (locked) begin
          if (owner_req) begin
            state_d = ISSUE;
          end else begin
            lock_cnt_run = 1'b1;
            timeout_hit  = ((12'(lock_cnt_q) + 12'd1) == LOCK_LIMIT);
          end
        end else if (pick_ok) begin
          start_grant = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        issue   = 1'b1;
        state_d = WAIT_DONE;
      end
      // The UART only raises busy after it has seen the write, so the first cycle is blind.
      WAIT_DONE: begin
        if (!wait_first_q && !bus.tx_busy) begin
          gap_load = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= NO_OWNER;
      last_grant_q <= 2'd2;
      lock_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      wait_first_q <= 1'b0;
      tx_in_q      <= 8'h00;
      tx_write_q   <= 1'b0;
      ack_q        <= 3'b000;
      lock_err_q   <= 1'b0;
    end else begin
      tx_write_q   <= issue;
      ack_q        <= issue ? (3'b001 << owner_q) : 3'b000;
      lock_err_q   <= timeout_hit;
      wait_first_q <= issue;

      if (start_grant) owner_q <= pick;

      if (issue) begin
        tx_in_q <= owner_data;
        if (owner_last) begin
          last_grant_q <= owner_q;
          owner_q      <= NO_OWNER;
        end
      end

      if (timeout_hit) begin
        last_grant_q <= owner_q;
        owner_q      <= NO_OWNER;
      end

      if (lock_cnt_run && !timeout_hit) lock_cnt_q <= lock_cnt_q + 11'd1;
      else                              lock_cnt_q <= '0;

      if (gap_load)                                gap_cnt_q <= GAP_LOAD;
      else if (state_q == GAP && gap_cnt_q != '0)  gap_cnt_q <= gap_cnt_q - 1'b1;
    end
  end

  assign bus.tx_in    = tx_in_q;
  assign bus.tx_write = tx_write_q;
  assign bus.ack      = ack_q;
  assign bus.owner    = owner_q;
  assign bus.lock_err = lock_err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: round-robin order, frame locking, UART busy
// handling with the inter-byte gap, lock timeout and asynchronous reset.
module tb_tx_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  tx_arbiter_if bus ();

  tx_arbiter #(
    .GAP_CYCLES   (16),
    .LOCK_TIMEOUT (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] req, input logic [2:0] last,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bus.req   = req;
    bus.last  = last;
    bus.data0 = d0;
    bus.data1 = d1;
    bus.data2 = d2;
  endtask

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
    bus.tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_write(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.tx_write !== 1'b1 && cycles < budget);
    check_output({tag, "_seen"}, 32'(bus.tx_write), 32'd1);
  endtask

  initial begin
    int cyc;
    int writes_seen;
    logic [7:0] exp_data [4];
    logic [2:0] exp_ack  [4];

    apply_stimulus(3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
    bus.tx_busy = 1'b0;
    #1;

    // Reset values, observed while reset is still asserted.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_tx_in",    32'(bus.tx_in),    32'h00);
    check_output("rst_tx_write", 32'(bus.tx_write), 32'd0);
    check_output("rst_ack",      32'(bus.ack),      32'd0);
    check_output("rst_owner",    32'(bus.owner),    32'd3);
    check_output("rst_lock_err", 32'(bus.lock_err), 32'd0);

    // Round robin with single-byte frames from all three requesters.
    do_reset();
    apply_stimulus(3'b111, 3'b111, 8'hA0, 8'hA1, 8'hA2);
    exp_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA0};
    exp_ack  = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 4; i++) begin
      wait_write($sformatf("rr%0d", i), 40, cyc);
      check_output($sformatf("rr%0d_cycles", i), 32'(cyc), (i == 0) ? 32'd2 : 32'd21);
      check_output($sformatf("rr%0d_tx_in", i),  32'(bus.tx_in), 32'(exp_data[i]));
      check_output($sformatf("rr%0d_ack", i),    32'(bus.ack),   32'(exp_ack[i]));
      check_output($sformatf("rr%0d_owner", i),  32'(bus.owner), 32'd3);
    end

    // Requester 1 sends a three-byte frame while requester 0 keeps asking.
    do_reset();
    apply_stimulus(3'b011, 3'b001, 8'h50, 8'h61, 8'h00);
    wait_write("fr_r0a", 40, cyc);
    check_output("fr_r0a_tx_in", 32'(bus.tx_in), 32'h50);
    check_output("fr_r0a_ack",   32'(bus.ack),   32'b001);
    wait_write("fr_b1", 40, cyc);
    check_output("fr_b1_tx_in", 32'(bus.tx_in), 32'h61);
    check_output("fr_b1_ack",   32'(bus.ack),   32'b010);
    check_output("fr_b1_owner", 32'(bus.owner), 32'd1);
    bus.data1 = 8'h62;
    wait_write("fr_b2", 40, cyc);
    check_output("fr_b2_cycles", 32'(cyc),        32'd21);
    check_output("fr_b2_tx_in",  32'(bus.tx_in), 32'h62);
    check_output("fr_b2_ack",    32'(bus.ack),   32'b010);
    check_output("fr_b2_owner",  32'(bus.owner), 32'd1);
    bus.data1 = 8'h63;
    bus.last  = 3'b011;
    wait_write("fr_b3", 40, cyc);
    check_output("fr_b3_tx_in", 32'(bus.tx_in), 32'h63);
    check_output("fr_b3_ack",   32'(bus.ack),   32'b010);
    check_output("fr_b3_owner", 32'(bus.owner), 32'd3);
    bus.req[1] = 1'b0;
    wait_write("fr_r0b", 40, cyc);
    check_output("fr_r0b_tx_in", 32'(bus.tx_in), 32'h50);
    check_output("fr_r0b_ack",   32'(bus.ack),   32'b001);

    // UART busy for 100 cycles stretches the spacing to 120 cycles.
    do_reset();
    apply_stimulus(3'b001, 3'b111, 8'h11, 8'h00, 8'h00);
    wait_write("busy_first", 40, cyc);
    check_output("busy_first_cycles", 32'(cyc),       32'd2);
    check_output("busy_first_tx_in",  32'(bus.tx_in), 32'h11);
    bus.tx_busy = 1'b1;
    bus.data0   = 8'h22;
    repeat (100) begin
      @(negedge clk);
      check_output("busy_hold_write", 32'(bus.tx_write), 32'd0);
    end
    bus.tx_busy = 1'b0;
    wait_write("busy_next", 60, cyc);
    check_output("busy_spacing",     32'(100 + cyc),  32'd120);
    check_output("busy_next_tx_in",  32'(bus.tx_in), 32'h22);

    // Requester 2 stalls mid-frame; lock expires and requester 0 takes over.
    do_reset();
    apply_stimulus(3'b100, 3'b000, 8'h0D, 8'h00, 8'hC2);
    wait_write("to_b1", 40, cyc);
    check_output("to_b1_tx_in", 32'(bus.tx_in), 32'hC2);
    check_output("to_b1_ack",   32'(bus.ack),   32'b100);
    check_output("to_b1_owner", 32'(bus.owner), 32'd2);
    apply_stimulus(3'b001, 3'b001, 8'h0D, 8'h00, 8'hC2);
    cyc = 0;
    writes_seen = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.tx_write === 1'b1) writes_seen++;
    end while (bus.lock_err !== 1'b1 && cyc < 1200);
    check_output("to_lock_err",     32'(bus.lock_err), 32'd1);
    check_output("to_cycles",       32'(cyc),          32'd1043);
    check_output("to_no_writes",    32'(writes_seen),  32'd0);
    check_output("to_err_ack",      32'(bus.ack),      32'd0);
    check_output("to_err_owner",    32'(bus.owner),    32'd3);
    @(negedge clk);
    check_output("to_err_pulse",    32'(bus.lock_err), 32'd0);
    check_output("to_new_owner",    32'(bus.owner),    32'd0);
    check_output("to_early_write",  32'(bus.tx_write), 32'd0);
    @(negedge clk);
    check_output("to_r0_write",     32'(bus.tx_write), 32'd1);
    check_output("to_r0_tx_in",     32'(bus.tx_in),    32'h0D);
    check_output("to_r0_ack",       32'(bus.ack),      32'b001);

    // Reset lands while a locked frame waits on the UART.
    do_reset();
    apply_stimulus(3'b001, 3'b000, 8'h0A, 8'h1B, 8'h00);
    wait_write("mr_b1", 40, cyc);
    check_output("mr_b1_owner", 32'(bus.owner), 32'd0);
    rst_n = 1'b0;
    #1;
    check_output("mr_tx_write", 32'(bus.tx_write), 32'd0);
    check_output("mr_ack",      32'(bus.ack),      32'd0);
    check_output("mr_owner",    32'(bus.owner),    32'd3);
    check_output("mr_tx_in",    32'(bus.tx_in),    32'h00);
    apply_stimulus(3'b010, 3'b010, 8'h0A, 8'h1B, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_write("mr_r1", 40, cyc);
    check_output("mr_r1_cycles", 32'(cyc),       32'd2);
    check_output("mr_r1_tx_in",  32'(bus.tx_in), 32'h1B);
    check_output("mr_r1_ack",    32'(bus.ack),   32'b010);

    // Simultaneous requests straight after reset: 0 before 1.
    do_reset();
    apply_stimulus(3'b011, 3'b111, 8'h30, 8'h31, 8'h00);
    wait_write("sim_a", 40, cyc);
    check_output("sim_a_tx_in", 32'(bus.tx_in), 32'h30);
    check_output("sim_a_ack",   32'(bus.ack),   32'b001);
    wait_write("sim_b", 40, cyc);
    check_output("sim_b_tx_in", 32'(bus.tx_in), 32'h31);
    check_output("sim_b_ack",   32'(bus.ack),   32'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
